ptf_moment_unit: RTL

//  Parametrised successor of the E[x^2] stage of the LayerNorm datapath. Streams one vector of
//  up to N_MAX signed samples through a valid/ready handshake and produces both E[x] and E[x^2].

---
 rtl/ptf_moment_unit.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/ptf_moment_unit.sv
// Streaming E[x] / E[x^2] moment unit with PTF (2^alpha) rescaling and saturating outputs.
// Build option: define AILN_MOMENT_EXACT_SQ_EN for exact mag*mag squares instead of the 4-bit LUT path.
module ptf_moment_unit #(
  parameter int unsigned N_MAX = 16,
  parameter int unsigned INV_W = 8,
  parameter int unsigned OUT_W = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic                         i_start,
  input  logic [$clog2(N_MAX+1)-1:0]   i_len,
  input  logic [INV_W-1:0]             i_inv_n,
  input  logic                         i_valid,
  input  logic signed [8:0]            i_x,
  input  logic [1:0]                   i_alpha,
  output logic                         o_ready,
  output logic                         o_busy,
  output logic                         o_done,
  output logic signed [OUT_W-1:0]      o_Ex,
  output logic [OUT_W-1:0]             o_Ex2,
  output logic                         o_ovf
);

  localparam int unsigned LEN_W = $clog2(N_MAX+1);
  localparam int unsigned ACC_W = 18 + $clog2(N_MAX) + 1;
`ifdef AILN_MOMENT_EXACT_SQ_EN
  // exact squares reach 22 bits per element, so the square accumulator grows to match
  localparam int unsigned EL_W  = 22;
`else
  localparam int unsigned EL_W  = 18;
`endif
  localparam int unsigned SQ_W  = EL_W + $clog2(N_MAX) + 1;
  localparam int unsigned PSQ_W = SQ_W + INV_W;
  localparam int unsigned PX_W  = ACC_W + INV_W + 1;
  localparam int unsigned QX_W  = ACC_W + 1;
  localparam int unsigned M1_W  = (SQ_W > QX_W) ? SQ_W : QX_W;
  localparam int unsigned WW    = ((M1_W > OUT_W) ? M1_W : OUT_W) + 2;

  localparam logic [WW-1:0]        U_MAX = (WW'(1) << OUT_W) - WW'(1);
  localparam logic signed [WW-1:0] S_MAX = (WW'(1) << (OUT_W - 1)) - WW'(1);
  localparam logic signed [WW-1:0] S_MIN = ~S_MAX;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_MUL, S_DONE} state_t;

  state_t state, state_nxt;

  logic [LEN_W-1:0]        len_q, cnt_q, cnt_inc, len_clamped;
  logic [INV_W-1:0]        inv_q;
  logic signed [ACC_W-1:0] sum_x;
  logic [SQ_W-1:0]         sum_sq;

  logic [7:0]              mag;
  logic signed [11:0]      xs;
  logic [EL_W-1:0]         sq_el;
  logic                    start_fire, acc_fire;

  // magnitude, -256 pinned to 255 so it fits 8 bits
  always_comb begin
    if (i_x == 9'sh100) begin
      mag = 8'd255;
    end else if (i_x[8]) begin
      mag = 8'(-i_x);
    end else begin
      mag = i_x[7:0];
    end
  end

`ifdef AILN_MOMENT_EXACT_SQ_EN
  logic [15:0] mag_sq;

  always_comb begin
    mag_sq = {8'd0, mag} * {8'd0, mag};
    sq_el  = {6'd0, mag_sq} << {i_alpha, 1'b0};
  end
`else
  function automatic logic [7:0] sq_lut(input logic [3:0] v);
    case (v)
      4'd0:    sq_lut = 8'd0;
      4'd1:    sq_lut = 8'd1;
      4'd2:    sq_lut = 8'd4;
      4'd3:    sq_lut = 8'd9;
      4'd4:    sq_lut = 8'd16;
      4'd5:    sq_lut = 8'd25;
      4'd6:    sq_lut = 8'd36;
      4'd7:    sq_lut = 8'd49;
      4'd8:    sq_lut = 8'd64;
      4'd9:    sq_lut = 8'd81;
      4'd10:   sq_lut = 8'd100;
      4'd11:   sq_lut = 8'd121;
      4'd12:   sq_lut = 8'd144;
      4'd13:   sq_lut = 8'd169;
      4'd14:   sq_lut = 8'd196;
      default: sq_lut = 8'd225;
    endcase
  endfunction

  logic [8:0] rnd_hi, rnd_lo;
  logic [4:0] c_hi;
  logic [6:0] c_lo;
  logic [3:0] c;
  logic [3:0] shamt;

  // rounded 4-bit code; both ranges clip at 15 instead of wrapping
  always_comb begin
    rnd_hi = {1'b0, mag} + 9'd8;
    rnd_lo = {1'b0, mag} + 9'd2;
    c_hi   = 5'(rnd_hi >> 4);
    c_lo   = 7'(rnd_lo >> 2);
    if (mag >= 8'd64) begin
      c     = (c_hi > 5'd15) ? 4'd15 : c_hi[3:0];
      shamt = 4'd4 + {1'b0, i_alpha, 1'b0};
    end else begin
      c     = (c_lo > 7'd15) ? 4'd15 : c_lo[3:0];
      shamt = {1'b0, i_alpha, 1'b0};
    end
    sq_el = {10'd0, sq_lut(c)} << shamt;
  end
`endif

  assign xs = $signed({{3{i_x[8]}}, i_x}) <<< i_alpha;

  assign start_fire  = (state == S_IDLE) && i_start;
  assign acc_fire    = (state == S_ACC) && i_valid;
  assign cnt_inc     = cnt_q + 1'b1;
  assign len_clamped = (i_len > LEN_W'(N_MAX)) ? LEN_W'(N_MAX) : i_len;

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_busy    = 1'b1;
    o_done    = 1'b0;
    case (state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          state_nxt = (len_clamped == '0) ? S_MUL : S_ACC;
        end
      end
      S_ACC: begin
        o_ready = 1'b1;
        if (i_valid && (cnt_inc == len_q)) begin
          state_nxt = S_MUL;
        end
      end
      S_MUL:   state_nxt = S_DONE;
      S_DONE: begin
        o_done    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // 1/len scaling and saturation, consumed only in MUL
  logic [PSQ_W-1:0]        prod_sq;
  logic signed [PX_W-1:0]  prod_x;
  logic [SQ_W-1:0]         q_sq;
  logic signed [QX_W-1:0]  q_x;
  logic [WW-1:0]           sq_w;
  logic signed [WW-1:0]    x_w;
  logic                    sat_sq, sat_hi, sat_lo;
  logic signed [OUT_W-1:0] ex_sat;
  logic [OUT_W-1:0]        ex2_sat;

  always_comb begin
    prod_sq = PSQ_W'(sum_sq) * PSQ_W'(inv_q);
    prod_x  = PX_W'(sum_x) * PX_W'($signed({1'b0, inv_q}));
    q_sq    = SQ_W'(prod_sq >> INV_W);
    q_x     = QX_W'(prod_x >>> INV_W);
    sq_w    = WW'(q_sq);
    x_w     = WW'(q_x);
    sat_sq  = sq_w > U_MAX;
    sat_hi  = x_w > S_MAX;
    sat_lo  = x_w < S_MIN;
    ex2_sat = sat_sq ? U_MAX[OUT_W-1:0] : sq_w[OUT_W-1:0];
    if (sat_hi) begin
      ex_sat = S_MAX[OUT_W-1:0];
    end else if (sat_lo) begin
      ex_sat = S_MIN[OUT_W-1:0];
    end else begin
      ex_sat = x_w[OUT_W-1:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      len_q  <= '0;
      inv_q  <= '0;
      cnt_q  <= '0;
      sum_x  <= '0;
      sum_sq <= '0;
      o_Ex   <= '0;
      o_Ex2  <= '0;
      o_ovf  <= 1'b0;
    end else begin
      if (start_fire) begin
        len_q  <= len_clamped;
        inv_q  <= i_inv_n;
        cnt_q  <= '0;
        sum_x  <= '0;
        sum_sq <= '0;
        o_Ex   <= '0;
        o_Ex2  <= '0;
        o_ovf  <= 1'b0;
      end
      if (acc_fire) begin
        cnt_q  <= cnt_inc;
        sum_x  <= sum_x + ACC_W'(xs);
        sum_sq <= sum_sq + SQ_W'(sq_el);
      end
      if (state == S_MUL) begin
        o_Ex  <= ex_sat;
        o_Ex2 <= ex2_sat;
        o_ovf <= sat_sq | sat_hi | sat_lo;
      end
    end
  end

endmodule
